control_booth: RTL and testbench
================================

# control_booth

Sequencing controller for the Booth shift-add multiplier datapath: accumulator A, multiplicand M, multiplier Q, the sum/subtract unit and the M/2M select mux. It accepts a start request, loads the operand registers, walks a fixed number of add/subtract-then-shift iterations by decoding the low multiplier bits, and signals completion. It drives only control lines; all data stays in the datapath.

## Interface
- SIZE, 4, operand width in bits; sets the iteration count. Must be even when radix-4 is compiled in.
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- inicio  in  1  start request, level-sampled in IDLE only
- q_bits  in  3  {Q[1], Q[0], q_1} from the datapath; q_1 is the extra bit below Q[0]
- carga_op  out  1  load M and Q from operand inputs, clear A and q_1
- carga_a  out  1  load A from the sum/subtract output
- resta  out  1  sum/subtract unit subtracts (1) or adds (0)
- sel_m2  out  1  mux selects 2M (1) or M (0)
- desplaza  out  1  arithmetic right shift of {A, Q, q_1}: 1 bit in radix-2, 2 bits in radix-4
- ocupado  out  1  high in every state except IDLE
- fin  out  1  one-cycle done pulse; product valid in {A, Q}

## Operation
- States: IDLE, LOAD, OPER, SHIFT, DONE. Counter cnt, width clog2(SIZE+1).
- IDLE: all outputs 0. If inicio=1, go to LOAD. Otherwise stay.
- LOAD: carga_op=1 and cnt <= ITER. ITER is SIZE in radix-2 and SIZE/2 in radix-4. Go to OPER.
- OPER: decode the digit combinationally from the q_bits sampled this cycle.
  - Digit nonzero: carga_a=1, with resta and sel_m2 set per the decode.
  - Digit zero: carga_a=0, resta=0, sel_m2=0.
  - Always go to SHIFT.
- Radix-2 decode uses {Q[0], q_1}:
  - 00 or 11: zero
  - 01: +M
  - 10: −M (resta=1)
- Radix-4 decode uses q_bits:
  - 000 or 111: zero
  - 001 or 010: +M
  - 011: +2M (sel_m2=1)
  - 100: −2M (resta=1, sel_m2=1)
  - 101 or 110: −M (resta=1)
- SHIFT: desplaza=1 and cnt <= cnt−1. If cnt==1, go to DONE; otherwise go to OPER.
- DONE: fin=1 for one cycle, then go to IDLE.
- inicio asserted outside IDLE, including in DONE, is ignored. A new operation needs inicio high in an IDLE cycle.
- carga_a and desplaza are never high in the same cycle. carga_op is high only in LOAD.
- reset: next state IDLE, cnt=0, all outputs 0 after the edge. This applies mid-operation too; the partial result is abandoned.

## Timing
- Reset value of every output is 0.
- inicio sampled at edge 0 → LOAD in cycle 1 → OPER/SHIFT pairs → fin high in cycle 2·ITER+2.
  - SIZE=4 radix-2: fin in cycle 10.
  - SIZE=4 radix-4: fin in cycle 6.
- Throughput: back-to-back operations are separated by at least one IDLE cycle. Minimum period is 2·ITER+3 cycles.
- q_bits must be stable in OPER cycles. It reflects the datapath after the previous SHIFT edge.

## Configuration
- BOOTH_RADIX4_EN
  - Defined: radix-4 decode, ITER=SIZE/2, desplaza means a 2-bit shift, sel_m2 is live.
  - Undefined: radix-2 decode on q_bits[1:0] with q_bits[2] ignored, ITER=SIZE, sel_m2 tied to 0.

## Structure
- Shared package multiplicador_pkg:
  - state encoding typedef: IDLE=0, LOAD=1, OPER=2, SHIFT=3, DONE=4
  - digit-operation typedef: ZERO, PLUS_M, PLUS_2M, MINUS_M, MINUS_2M
  - ITER constant function of SIZE
- One sub-module, decod_booth: purely combinational, q_bits → {nonzero, resta, sel_m2}. It holds the radix-2/radix-4 split under the macro.
- The FSM and counter live in control_booth.

## Test plan
- Reset during SHIFT with SIZE=4 → next cycle all outputs 0, ocupado=0, state IDLE; a following inicio pulse starts a clean run.
- Radix-2, M=0011, Q=1110, datapath model closing the loop:
  - OPER ops in order: zero, −M, zero, zero.
  - fin in cycle 10; {A,Q}=1111_1010 (−6).
- Radix-4, same operands:
  - OPER ops: −2M (q_bits=100) then zero (111).
  - fin in cycle 6; product −6.
- Radix-4, M=0011, Q=0011 → OPER ops −M (110) then +M (001); product 9 = 0000_1001.
- inicio held high through a whole run → ignored while ocupado; exactly one IDLE cycle, then a second run starts; fin pulses exactly once per run.
- Every OPER/SHIFT cycle → assert carga_a & desplaza never both high; carga_op only in the LOAD cycle.

Source files
------------

// File: rtl/multiplicador_pkg.sv
// Shared types for the Booth multiplier controller.
// BOOTH_RADIX4_EN selects radix-4 recoding (two multiplier bits per iteration).
package multiplicador_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    OPER  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    PLUS_M,
    PLUS_2M,
    MINUS_M,
    MINUS_2M
  } digit_t;

  // Number of add/shift iterations for an operand width of size bits.
  function automatic int iter_f(input int size);
`ifdef BOOTH_RADIX4_EN
    return size / 2;
`else
    return size;
`endif
  endfunction

endpackage

// File: rtl/decod_booth.sv
// Combinational Booth digit decoder: multiplier bits -> {nonzero, subtract, select 2M}.
// BOOTH_RADIX4_EN selects the radix-4 table; otherwise radix-2 on {Q[0], q_1}.
module decod_booth
  import multiplicador_pkg::*;
(
  input  logic [2:0] i_q_bits,
  output logic       o_nonzero,
  output logic       o_resta,
  output logic       o_sel_m2
);

  digit_t w_digit;

  always_comb begin
    w_digit = ZERO;
`ifdef BOOTH_RADIX4_EN
    case (i_q_bits)
      3'b001, 3'b010: w_digit = PLUS_M;
      3'b011:         w_digit = PLUS_2M;
      3'b100:         w_digit = MINUS_2M;
      3'b101, 3'b110: w_digit = MINUS_M;
      default:        w_digit = ZERO;
    endcase
`else
    // Q[1] plays no part in radix-2 recoding.
    casez (i_q_bits)
      3'b?01:  w_digit = PLUS_M;
      3'b?10:  w_digit = MINUS_M;
      default: w_digit = ZERO;
    endcase
`endif
  end

  assign o_nonzero = (w_digit != ZERO);
  assign o_resta   = (w_digit == MINUS_M) || (w_digit == MINUS_2M);
`ifdef BOOTH_RADIX4_EN
  assign o_sel_m2  = (w_digit == PLUS_2M) || (w_digit == MINUS_2M);
`else
  assign o_sel_m2  = 1'b0;
`endif

endmodule

// File: rtl/control_booth.sv
// Sequencing FSM for the Booth shift-add multiplier datapath (control lines only).
// BOOTH_RADIX4_EN selects radix-4 operation (SIZE/2 iterations, 2-bit shifts).
module control_booth
  import multiplicador_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic [2:0] q_bits,
  output logic       carga_op,
  output logic       carga_a,
  output logic       resta,
  output logic       sel_m2,
  output logic       desplaza,
  output logic       ocupado,
  output logic       fin
);

  localparam int              CNT_W  = $clog2(SIZE + 1);
  localparam int              ITER   = iter_f(SIZE);
  localparam logic [CNT_W-1:0] ITER_C = CNT_W'(ITER);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_nonzero;
  logic w_resta;
  logic w_sel_m2;

  decod_booth u_decod (
    .i_q_bits  (q_bits),
    .o_nonzero (w_nonzero),
    .o_resta   (w_resta),
    .o_sel_m2  (w_sel_m2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE:  if (inicio) w_state_nxt = LOAD;
      LOAD: begin
        w_cnt_nxt   = ITER_C;
        w_state_nxt = OPER;
      end
      OPER:  w_state_nxt = SHIFT;
      SHIFT: begin
        w_cnt_nxt   = r_cnt - ONE_C;
        w_state_nxt = (r_cnt == ONE_C) ? DONE : OPER;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath strobes; the decoder is consulted only in OPER.
  always_comb begin
    carga_op = 1'b0;
    carga_a  = 1'b0;
    resta    = 1'b0;
    sel_m2   = 1'b0;
    desplaza = 1'b0;
    fin      = 1'b0;
    ocupado  = (r_state != IDLE);
    case (r_state)
      LOAD:  carga_op = 1'b1;
      OPER: begin
        carga_a = w_nonzero;
        resta   = w_nonzero & w_resta;
        sel_m2  = w_nonzero & w_sel_m2;
      end
      SHIFT: desplaza = 1'b1;
      DONE:  fin = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_booth.sv
// Scoreboard bench for control_booth with a behavioural datapath closing the loop.
module tb_control_booth;

  localparam int SIZE = 4;
`ifdef BOOTH_RADIX4_EN
  localparam int ITER = SIZE / 2;
  localparam int SH   = 2;
`else
  localparam int ITER = SIZE;
  localparam int SH   = 1;
`endif

  typedef struct {
    int s;
    int prod;
  } txn_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       inicio;
  logic [2:0] q_bits;
  logic       carga_op, carga_a, resta, sel_m2, desplaza, ocupado, fin;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  txn_t txn_q[$];
  int   dig_q[$];
  txn_t cur;
  int   active = 0;
  int   nops   = 0;

  logic [SIZE-1:0] op_m, op_q;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  control_booth #(.SIZE(SIZE)) dut (
    .clk      (clk),
    .reset    (reset),
    .inicio   (inicio),
    .q_bits   (q_bits),
    .carga_op (carga_op),
    .carga_a  (carga_a),
    .resta    (resta),
    .sel_m2   (sel_m2),
    .desplaza (desplaza),
    .ocupado  (ocupado),
    .fin      (fin)
  );

  // Behavioural datapath: A carries two guard bits so radix-4 2M never overflows.
  logic signed [SIZE+1:0]   r_a;
  logic        [SIZE-1:0]   r_q;
  logic        [SIZE-1:0]   r_m;
  logic                     r_q1;
  wire  signed [SIZE+1:0]   w_m_ext   = {{2{r_m[SIZE-1]}}, r_m};
  wire  signed [SIZE+1:0]   w_addend  = sel_m2 ? (w_m_ext <<< 1) : w_m_ext;
  wire  signed [2*SIZE+2:0] w_shifted = $signed({r_a, r_q, r_q1}) >>> SH;
  wire  signed [2*SIZE+1:0] w_prod    = {r_a, r_q};
  assign q_bits = {r_q[1], r_q[0], r_q1};

  always @(posedge clk) begin
    if (carga_op) begin
      r_a  <= '0;
      r_q  <= op_q;
      r_m  <= op_m;
      r_q1 <= 1'b0;
    end else if (carga_a) begin
      r_a <= resta ? (r_a - w_addend) : (r_a + w_addend);
    end else if (desplaza) begin
      {r_a, r_q, r_q1} <= w_shifted;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected response from plain arithmetic and Booth recoding of the multiplier.
  task automatic push_txn(input int s, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    txn_t t;
    logic [SIZE:0] bx;
    t.s    = s;
    t.prod = int'($signed(a)) * int'($signed(b));
    txn_q.push_back(t);
    bx = {b, 1'b0};
    for (int i = 0; i < ITER; i++) begin
      if (SH == 2)
        dig_q.push_back(int'(bx[2*i]) + int'(bx[2*i+1]) - 2 * int'(bx[2*i+2]));
      else
        dig_q.push_back(int'(bx[i]) - int'(bx[i+1]));
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!ocupado) return;
    end
    chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    wait_idle();
    op_m   = a;
    op_q   = b;
    inicio = 1'b1;
    push_txn(cyc, a, b);
    @(negedge clk);
    inicio = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'({carga_op, carga_a, resta, sel_m2, desplaza, ocupado, fin}), 0);
  endtask

  // Monitor: pops expectations whenever the DUT shows a load, an OPER decision or done.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (carga_a && desplaza) chk("carga_a_and_desplaza", 1, 0);
      if (!ocupado && (carga_op || carga_a || resta || sel_m2 || desplaza || fin))
        chk("idle_outputs", 1, 0);
      if (carga_op) begin
        if (txn_q.size() == 0) begin
          chk("unexpected_load", 1, 0);
        end else begin
          cur    = txn_q.pop_front();
          active = 1;
          nops   = 0;
          chk("load_cycle", cyc, cur.s + 1);
        end
      end else if (ocupado && !desplaza && !fin) begin
        int obs;
        obs = carga_a ? ((resta ? -1 : 1) * (sel_m2 ? 2 : 1)) : ((resta || sel_m2) ? 99 : 0);
        nops++;
        if (dig_q.size() == 0) chk("unexpected_oper", 1, 0);
        else chk("oper_digit", obs, dig_q.pop_front());
      end
      if (fin) begin
        if (active == 0) begin
          chk("unexpected_fin", 1, 0);
        end else begin
          chk("fin_cycle", cyc, cur.s + 2 * ITER + 2);
          chk("product", int'(w_prod), cur.prod);
          chk("oper_count", nops, ITER);
          chk("ocupado_in_done", int'(ocupado), 1);
          active = 0;
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    inicio = 1'b0;
    op_m   = '0;
    op_q   = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    reset = 1'b0;

    // Directed operands from the worked examples.
    issue(4'b0011, 4'b1110);
    issue(4'b0011, 4'b0011);

    // Abort a run in its first SHIFT cycle.
    issue(4'b0011, 4'b1110);
    begin
      int seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
        if (desplaza) seen = 1;
        else @(negedge clk);
      end
      chk("reached_shift", seen, 1);
    end
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("reset_mid_run");
    chk("ocupado_after_reset", int'(ocupado), 0);
    txn_q.delete();
    dig_q.delete();
    active = 0;
    reset  = 1'b0;
    issue(4'b0101, 4'b1001);

    // inicio held across a whole run: exactly one IDLE cycle, then a second run.
    wait_idle();
    op_m   = 4'b0011;
    op_q   = 4'b0011;
    inicio = 1'b1;
    begin
      int s1;
      s1 = cyc;
      push_txn(s1, op_m, op_q);
      push_txn(s1 + 2 * ITER + 3, op_m, op_q);
    end
    repeat (2 * ITER + 4) @(negedge clk);
    inicio = 1'b0;

    // Randomised operands, including the extremes.
    issue(4'b1000, 4'b1000);
    issue(4'b0111, 4'b1000);
    for (int n = 0; n < 24; n++)
      issue(SIZE'($urandom_range(0, 15)), SIZE'($urandom_range(0, 15)));

    wait_idle();
    repeat (3) @(negedge clk);
    chk("pending_txns", txn_q.size(), 0);
    chk("pending_digits", dig_q.size(), 0);
    chk("run_open", active, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
